accounter_wrsched: RTL and testbench

Write-side scheduler for the accounter tracking RAM. It collects write notifications from NB_WRAGENT write agents and serialises them onto the accounter RAM's single write port, one update per cycle, with round-robin fairness and last-writer-wins ordering per address. After reset it can optionally sweep the tracking RAM to a known agent ID before accepting traffic.

---
 rtl/accounter_wrsched.sv | 162 ++++++++++++++++
 tb/tb_accounter_wrsched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accounter_wrsched.sv
// Write-side scheduler for the accounter tracking RAM: one-entry pending slot per agent,
// round-robin onto the single RAM write port. Define ACCOUNTER_INIT_EN for the post-reset RAM sweep.
module accounter_wrsched #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
  parameter int NB_WRAGENT   = 2,
  parameter int SELECT_WIDTH = $clog2(NB_WRAGENT)
) (
  input  logic                             aclk,
  input  logic                             srst,
  input  logic [NB_WRAGENT-1:0]            agt_wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] agt_wraddr,
  output logic [NB_WRAGENT-1:0]            agt_ready,
  output logic                             acc_wren,
  output logic [ADDR_WIDTH-1:0]            acc_wraddr,
  output logic [SELECT_WIDTH-1:0]          acc_wrdata,
  output logic                             init_done
);

  if (NB_WRAGENT < 2 || RAM_DEPTH < 1 || RAM_DEPTH > 2**ADDR_WIDTH) begin : g_param_check
    $error("accounter_wrsched: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0]   req_addr  [NB_WRAGENT];
  logic [ADDR_WIDTH-1:0]   slot_addr [NB_WRAGENT];
  logic [NB_WRAGENT-1:0]   slot_valid;
  logic [NB_WRAGENT-1:0]   valid_d;
  logic [NB_WRAGENT-1:0]   accept;
  logic [NB_WRAGENT-1:0]   grant;
  logic [NB_WRAGENT-1:0]   kill;
  logic [SELECT_WIDTH-1:0] rr_ptr;
  logic [SELECT_WIDTH-1:0] gidx;
  logic                    run_d;
  logic                    sweeping;
  logic [ADDR_WIDTH-1:0]   sweep_addr;

  always_comb begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      req_addr[i] = agt_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Round-robin: search begins one past the last granted agent.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int off = 1; off <= NB_WRAGENT; off++) begin
      idx = (int'(rr_ptr) + off) % NB_WRAGENT;
      if (!found && slot_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = SELECT_WIDTH'(idx);
      end
    end
  end

  // A granted slot frees itself this cycle, so the agent can refill it on the same edge.
  assign agt_ready = {NB_WRAGENT{init_done}} & (~slot_valid | grant);
  assign accept    = agt_wren & agt_ready;

  // Last writer wins: a new acceptance at an address voids older pending writes to it,
  // and among simultaneous acceptances at one address only the highest agent survives.
  always_comb begin
    kill = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int k = 0; k < NB_WRAGENT; k++) begin
        if (k != i && accept[k]) begin
          if (accept[i]) begin
            if (k > i && req_addr[k] == req_addr[i]) kill[i] = 1'b1;
          end else if (slot_valid[i] && req_addr[k] == slot_addr[i]) begin
            kill[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = slot_valid;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (accept[i])                valid_d[i] = ~kill[i];
      else if (grant[i] || kill[i]) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (srst) begin
      slot_valid <= '0;
      rr_ptr     <= SELECT_WIDTH'(NB_WRAGENT-1);
      acc_wren   <= 1'b0;
      acc_wraddr <= '0;
      acc_wrdata <= '0;
      init_done  <= 1'b0;
    end else begin
      slot_valid <= valid_d;
      init_done  <= run_d;
      if (sweeping) begin
        acc_wren   <= 1'b1;
        acc_wraddr <= sweep_addr;
        acc_wrdata <= '0;
      end else begin
        acc_wren <= |grant;
        if (|grant) begin
          acc_wraddr <= slot_addr[gidx];
          acc_wrdata <= gidx;
          rr_ptr     <= gidx;
        end
      end
    end
  end

  // NOTE: slot addresses are storage qualified by slot_valid, so they carry no reset.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (accept[i]) slot_addr[i] <= req_addr[i];
    end
  end

`ifdef ACCOUNTER_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      if (sweep_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        state_d = ST_RUN;
        sweep_d = '0;
      end else begin
        sweep_d = sweep_q + 1'b1;
      end
    end
  end

  assign sweeping   = (state_q == ST_INIT);
  assign sweep_addr = sweep_q;
  assign run_d      = (state_q == ST_RUN);
`else
  assign sweeping   = 1'b0;
  assign sweep_addr = '0;
  assign run_d      = 1'b1;
`endif

endmodule

// File: tb/tb_accounter_wrsched.sv
// Scoreboard bench for accounter_wrsched: a cycle model of agents, slots and the
// round-robin rule queues expected RAM writes; a monitor pops them as the DUT writes.
module tb_accounter_wrsched;

  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int SW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef ACCOUNTER_INIT_EN
  localparam int START = DEPTH + 1;
  localparam bit SWEEP = 1'b1;
`else
  localparam int START = 1;
  localparam bit SWEEP = 1'b0;
`endif

  logic             aclk;
  logic             srst;
  logic [NB-1:0]    agt_wren;
  logic [NB*AW-1:0] agt_wraddr;
  logic [NB-1:0]    agt_ready;
  logic             acc_wren;
  logic [AW-1:0]    acc_wraddr;
  logic [SW-1:0]    acc_wrdata;
  logic             init_done;

  accounter_wrsched #(
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH),
    .NB_WRAGENT (NB),
    .SELECT_WIDTH(SW)
  ) dut (
    .aclk       (aclk),
    .srst       (srst),
    .agt_wren   (agt_wren),
    .agt_wraddr (agt_wraddr),
    .agt_ready  (agt_ready),
    .acc_wren   (acc_wren),
    .acc_wraddr (acc_wraddr),
    .acc_wrdata (acc_wrdata),
    .init_done  (init_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int addr;
    int id;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  compared;
  int  mismatched;
  int  id_cnt [NB];

  // Reference model state: pending write per agent, last granted agent.
  bit  pv [NB];
  int  pa [NB];
  int  last_grant;
  int  since_rst;
  bit  exp_wren;

  // Agent behaviour: a request is held until it is accepted.
  bit  req_v    [NB];
  int  req_a    [NB];
  bit  accepted [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    int a;
    for (int off = 1; off <= NB; off++) begin
      a = (last_grant + off) % NB;
      if (pv[a]) return a;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NB; i++) if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: compare the DUT to the model, drive the next inputs, advance the model.
  task automatic tick(input bit rst);
    int            g;
    logic [NB-1:0] rdy;
    bit            run;
    run = (since_rst >= START);
    g   = run ? model_pick() : -1;
    for (int i = 0; i < NB; i++) rdy[i] = run && (!pv[i] || g == i);
    check("agt_ready", 32'(agt_ready), 32'(rdy));
    check("init_done", 32'(init_done), 32'(run));
    check("acc_wren",  32'(acc_wren),  32'(exp_wren));

    srst = rst;
    for (int i = 0; i < NB; i++) begin
      agt_wren[i]              = req_v[i];
      agt_wraddr[i*AW +: AW]   = AW'(req_a[i]);
      accepted[i]              = 1'b0;
    end

    exp_wren = 1'b0;
    if (rst) begin
      for (int i = 0; i < NB; i++) pv[i] = 1'b0;
      last_grant = NB - 1;
      since_rst  = 0;
    end else begin
      if (SWEEP && since_rst < DEPTH) begin
        exp_q.push_back('{since_rst, 0});
        exp_wren = 1'b1;
      end
      if (g >= 0) begin
        exp_q.push_back('{pa[g], g});
        exp_wren   = 1'b1;
        pv[g]      = 1'b0;
        last_grant = g;
      end
      for (int j = 0; j < NB; j++) begin
        if (req_v[j] && rdy[j]) begin
          accepted[j] = 1'b1;
          for (int k = 0; k < NB; k++) begin
            if (k != j && pv[k] && pa[k] == req_a[j]) pv[k] = 1'b0;
          end
          pv[j] = 1'b1;
          pa[j] = req_a[j];
        end
      end
      since_rst++;
    end
    @(negedge aclk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NB; i++) req_v[i] = 1'b0;
  endtask

  task automatic request(input int agent, input int addr);
    req_v[agent] = 1'b1;
    req_a[agent] = addr;
  endtask

  task automatic drain();
    clear_reqs();
    for (int n = 0; n < 64 && (any_pending() || exp_wren); n++) tick(1'b0);
    tick(1'b0);
  endtask

  task automatic random_phase(input int ncyc, input int pct, input int amax);
    repeat (ncyc) begin
      for (int j = 0; j < NB; j++) begin
        if (req_v[j] && accepted[j]) req_v[j] = 1'b0;
        if (!req_v[j] && $urandom_range(99) < pct) begin
          req_v[j] = 1'b1;
          req_a[j] = $urandom_range(amax - 1);
        end
      end
      tick(1'b0);
    end
  endtask

  // Monitor: every DUT write must match the oldest expected write.
  always @(negedge aclk) begin
    if (acc_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0h id %0h, expected no write (t=%0t)",
                 acc_wraddr, acc_wrdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_wraddr", 32'(acc_wraddr), 32'(mon_e.addr));
        check("acc_wrdata", 32'(acc_wrdata), 32'(mon_e.id));
      end
      id_cnt[acc_wrdata]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    last_grant = NB - 1;
    since_rst  = 0;
    exp_wren   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      pv[i] = 1'b0; pa[i] = 0; req_v[i] = 1'b0; req_a[i] = 0; accepted[i] = 1'b0; id_cnt[i] = 0;
    end
    srst       = 1'b1;
    agt_wren   = '0;
    agt_wraddr = '0;
    @(negedge aclk);

    // Reset state
    repeat (3) tick(1'b1);
    check("reset_acc_wraddr", 32'(acc_wraddr), 32'd0);
    check("reset_acc_wrdata", 32'(acc_wrdata), 32'd0);

    // Release: sweep (when compiled in), then RUN
    repeat (START + 2) tick(1'b0);

    // Single agent: agent 1 writes 0x5 once
    request(1, 5);
    tick(1'b0);
    drain();

    // Randomised traffic with heavy address overlap, then wide addresses
    random_phase(300, 60, 4);
    drain();
    random_phase(200, 50, 16);
    drain();

    // Fairness: all agents stream, distinct addresses per agent
    for (int i = 0; i < NB; i++) id_cnt[i] = 0;
    repeat (40) begin
      for (int j = 0; j < NB; j++) begin
        if (!req_v[j] || accepted[j]) begin
          req_v[j] = 1'b1;
          req_a[j] = j * 4 + int'($urandom_range(3));
        end
      end
      tick(1'b0);
    end
    drain();
    for (int i = 0; i < NB; i++) begin
      check("fairness_share", 32'(id_cnt[i] >= 10 && id_cnt[i] <= 11), 32'd1);
    end

    // Supersede across cycles: agent 0 at 0xB is voided by agent 1 at 0xB
    request(2, 1); request(3, 2);
    tick(1'b0); clear_reqs();
    request(0, 11);
    tick(1'b0); clear_reqs();
    request(1, 11);
    tick(1'b0);
    drain();

    // Same-cycle collision: agents 0,1,2 at 0xA
    request(0, 10); request(1, 10); request(2, 10);
    tick(1'b0); clear_reqs();
    tick(1'b0);
    drain();

    // Reset mid-RUN with three slots pending
    for (int j = 0; j < NB; j++) request(j, 8 + j);
    tick(1'b0); clear_reqs();
    tick(1'b0);
    tick(1'b1);
    repeat (START + 2) tick(1'b0);

    random_phase(100, 40, 8);
    drain();

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
